// File: rtl/delay_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : delay_param_sequencer
// Purpose  : Click-free sequencer for the delay stage configuration inputs.
// Revision : 1.0 - initial release
// ============================================================================
module delay_param_sequencer #(
  parameter int DELAY_WIDTH = 16,
  parameter int MAX_DELAY   = 16384,
  parameter int RESET_DELAY = 4800,
  parameter int RAMP_STEP   = 4,
  parameter int MUTE_HOLD   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   cfg_enable,
  input  logic [DELAY_WIDTH-1:0] cfg_delay_length,
  input  logic [7:0]             cfg_feedback,
  input  logic [7:0]             cfg_wet,
  input  logic                   sample_tick,
  input  logic                   sample_last,
  output logic                   delay_enable,
  output logic [DELAY_WIDTH-1:0] delay_length,
  output logic [7:0]             feedback_level,
  output logic [7:0]             wet_level,
  output logic                   busy
);

  localparam int                     c_HOLD_W    = $clog2(MUTE_HOLD + 1);
  localparam logic [DELAY_WIDTH-1:0] c_MAX_LEN   = DELAY_WIDTH'(MAX_DELAY);
  localparam logic [DELAY_WIDTH-1:0] c_MIN_LEN   = DELAY_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0] c_RESET_LEN = DELAY_WIDTH'(RESET_DELAY);
  localparam logic [8:0]             c_STEP      = 9'(RAMP_STEP);
  localparam logic [c_HOLD_W-1:0]    c_HOLD_LOAD = c_HOLD_W'(MUTE_HOLD);
  localparam logic [c_HOLD_W-1:0]    c_HOLD_ONE  = c_HOLD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_SWITCH   = 3'd2,
    S_HOLD     = 3'd3,
    S_GLIDE    = 3'd4
  } state_t;

  state_t                 r_state;
  logic                   r_tgt_en;
  logic [DELAY_WIDTH-1:0] r_tgt_len;
  logic [7:0]             r_tgt_fb;
  logic [7:0]             r_tgt_wet;
  logic [c_HOLD_W-1:0]    r_hold_cnt;

  logic                   w_frame_tick;
  logic                   w_accept;
  logic [DELAY_WIDTH-1:0] w_cfg_len;
  logic                   w_needs_fade;
  logic                   w_levels_zero;
  logic                   w_levels_at_tgt;

  // Reduce toward zero by at most one step, never below zero.
  function automatic logic [7:0] fade_step(input logic [7:0] cur);
    logic [8:0] v;
    v = {1'b0, cur};
    if (v <= c_STEP) v = 9'd0;
    else             v = v - c_STEP;
    return v[7:0];
  endfunction

  // Move toward the target by at most one step, snapping when within reach.
  function automatic logic [7:0] glide_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] c;
    logic [8:0] t;
    logic [8:0] d;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (c < t) begin
      d = t - c;
      if (d <= c_STEP) c = t;
      else             c = c + c_STEP;
    end else begin
      d = c - t;
      if (d <= c_STEP) c = t;
      else             c = c - c_STEP;
    end
    return c[7:0];
  endfunction

  assign w_frame_tick    = sample_tick && sample_last;
  assign cfg_ready       = (r_state == S_IDLE) && !reset;
  assign w_accept        = cfg_valid && cfg_ready;
  assign busy            = (r_state != S_IDLE);
  assign w_levels_zero   = (wet_level == 8'd0) && (feedback_level == 8'd0);
  assign w_levels_at_tgt = (wet_level == r_tgt_wet) && (feedback_level == r_tgt_fb);

  always_comb begin
    w_cfg_len = cfg_delay_length;
    if (cfg_delay_length == '0) begin
      w_cfg_len = c_MIN_LEN;
    end else if (cfg_delay_length > c_MAX_LEN) begin
      w_cfg_len = c_MAX_LEN;
    end
  end

  // Any change to enable, or a new length while running, must pass through silence.
  assign w_needs_fade = (cfg_enable != delay_enable) ||
                        (cfg_enable && (w_cfg_len != delay_length));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_tgt_en       <= 1'b0;
      r_tgt_len      <= '0;
      r_tgt_fb       <= 8'd0;
      r_tgt_wet      <= 8'd0;
      r_hold_cnt     <= '0;
      delay_enable   <= 1'b0;
      delay_length   <= c_RESET_LEN;
      feedback_level <= 8'd0;
      wet_level      <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tgt_en  <= cfg_enable;
            r_tgt_len <= w_cfg_len;
            r_tgt_fb  <= cfg_feedback;
            r_tgt_wet <= cfg_wet;
            if (w_needs_fade)    r_state <= S_FADE_OUT;
            else if (cfg_enable) r_state <= S_GLIDE;
            else                 r_state <= S_SWITCH;
          end
        end

        S_FADE_OUT: begin
          if (w_levels_zero) begin
            r_state <= S_SWITCH;
          end else if (w_frame_tick) begin
            wet_level      <= fade_step(wet_level);
            feedback_level <= fade_step(feedback_level);
          end
        end

        S_SWITCH: begin
          if (w_frame_tick) begin
            delay_length <= r_tgt_len;
            delay_enable <= r_tgt_en;
            if (r_tgt_en) begin
              r_hold_cnt <= c_HOLD_LOAD;
              r_state    <= S_HOLD;
            end else begin
              r_tgt_fb  <= 8'd0;
              r_tgt_wet <= 8'd0;
              r_state   <= S_IDLE;
            end
          end
        end

        S_HOLD: begin
          if (w_frame_tick) begin
            r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;
            if (r_hold_cnt == c_HOLD_ONE) r_state <= S_GLIDE;
          end
        end

        S_GLIDE: begin
          if (w_levels_at_tgt) begin
            r_state <= S_IDLE;
          end else if (w_frame_tick) begin
            wet_level      <= glide_step(wet_level, r_tgt_wet);
            feedback_level <= glide_step(feedback_level, r_tgt_fb);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_delay_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_param_sequencer
// Purpose  : Randomised self-checking bench with a per-frame-tick reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_param_sequencer;

  localparam int c_MAXD = 16384;
  localparam int c_RSTD = 4800;
  localparam int c_STEP = 4;
  localparam int c_HOLD = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_enable;
  logic [15:0] cfg_delay_length;
  logic [7:0]  cfg_feedback;
  logic [7:0]  cfg_wet;
  logic        sample_tick;
  logic        sample_last;
  logic        delay_enable;
  logic [15:0] delay_length;
  logic [7:0]  feedback_level;
  logic [7:0]  wet_level;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int acc_seen = 0;

  // Reference model: current outputs and the per-tick expected trajectory.
  int          m_en;
  int          m_len;
  int          m_fb;
  int          m_wet;
  logic [32:0] exp_now;
  logic [32:0] q[$];

  logic [15:0] p_len;
  logic        p_en;
  logic [7:0]  p_fb;
  logic [7:0]  p_wet;

  always #5 clk = ~clk;

  delay_param_sequencer #(
    .DELAY_WIDTH(16),
    .MAX_DELAY  (c_MAXD),
    .RESET_DELAY(c_RSTD),
    .RAMP_STEP  (c_STEP),
    .MUTE_HOLD  (c_HOLD)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_enable      (cfg_enable),
    .cfg_delay_length(cfg_delay_length),
    .cfg_feedback    (cfg_feedback),
    .cfg_wet         (cfg_wet),
    .sample_tick     (sample_tick),
    .sample_last     (sample_last),
    .delay_enable    (delay_enable),
    .delay_length    (delay_length),
    .feedback_level  (feedback_level),
    .wet_level       (wet_level),
    .busy            (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [32:0] actual();
    return {delay_enable, delay_length, feedback_level, wet_level};
  endfunction

  function automatic logic [32:0] snap();
    return {1'(m_en), 16'(m_len), 8'(m_fb), 8'(m_wet)};
  endfunction

  function automatic int toward(input int c, input int t);
    if (c < t) return (t - c <= c_STEP) ? t : c + c_STEP;
    return (c - t <= c_STEP) ? t : c - c_STEP;
  endfunction

  // Expected output after every frame tick needed to reach the request.
  task automatic build(input int te, input int raw, input int tf, input int tw);
    int tl;
    tl = (raw == 0) ? 1 : ((raw > c_MAXD) ? c_MAXD : raw);
    q.delete();
    exp_now = snap();
    if (te != m_en || (te != 0 && tl != m_len) || te == 0) begin
      while (m_fb > 0 || m_wet > 0) begin
        m_fb  -= (m_fb  < c_STEP) ? m_fb  : c_STEP;
        m_wet -= (m_wet < c_STEP) ? m_wet : c_STEP;
        q.push_back(snap());
      end
      m_len = tl;
      m_en  = te;
      q.push_back(snap());
      if (te == 0) return;
      repeat (c_HOLD) q.push_back(snap());
    end
    while (m_fb != tf || m_wet != tw) begin
      m_fb  = toward(m_fb, tf);
      m_wet = toward(m_wet, tw);
      q.push_back(snap());
    end
  endtask

  always @(posedge clk) begin
    if (cfg_valid && cfg_ready) acc_cnt <= acc_cnt + 1;
  end

  // Length/enable may only move while both levels are silent.
  always @(negedge clk) begin
    if (!reset && (delay_length !== p_len || delay_enable !== p_en))
      check_val("invariant", {p_fb, p_wet, feedback_level, wet_level}, 64'd0);
    p_len <= delay_length;
    p_en  <= delay_enable;
    p_fb  <= feedback_level;
    p_wet <= wet_level;
  end

  task automatic wait_accept();
    int k;
    k = 0;
    while (acc_cnt == acc_seen && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("accept", 64'(acc_cnt != acc_seen), 64'd1);
    acc_seen = acc_cnt;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic present(input int te, input int len, input int fb, input int wt);
    @(negedge clk);
    cfg_enable       = 1'(te);
    cfg_delay_length = 16'(len);
    cfg_feedback     = 8'(fb);
    cfg_wet          = 8'(wt);
    cfg_valid        = 1'b1;
  endtask

  task automatic send(input int te, input int len, input int fb, input int wt);
    present(te, len, fb, wt);
    wait_accept();
    build(te, len, fb, wt);
  endtask

  // Frame ticks are spaced so none lands on a state-transition cycle.
  task automatic play(input int n_max, input bit final_chk);
    int n;
    n = 0;
    while (q.size() > 0 && n < n_max) begin
      int gap;
      gap = $urandom_range(2, 4);
      repeat (gap) begin
        @(negedge clk);
        sample_tick = 1'($urandom_range(0, 1));
        sample_last = 1'b0;
        @(posedge clk); #1;
        check_val("gated", actual(), exp_now);
      end
      @(negedge clk);
      check_val("busy_run", busy, 1);
      sample_tick = 1'b1;
      sample_last = 1'b1;
      @(posedge clk); #1;
      exp_now = q.pop_front();
      check_val("tick", actual(), exp_now);
      n++;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    sample_last = 1'b0;
    if (final_chk) begin
      @(posedge clk);
      @(posedge clk); #1;
      check_val("done_busy", busy, 0);
      check_val("done_ready", cfg_ready, 1);
      check_val("done_out", actual(), exp_now);
    end else begin
      check_val("stall_hold", acc_cnt, acc_seen);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_len = c_RSTD; m_fb = 0; m_wet = 0;
    exp_now = snap();
    q.delete();
  endtask

  task automatic reset_mid();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_val("rst_out", actual(), {1'b0, 16'd4800, 8'd0, 8'd0});
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", cfg_ready, 0);
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_enable = 1'b0; cfg_delay_length = '0;
    cfg_feedback = '0; cfg_wet = '0; sample_tick = 1'b0; sample_last = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("por_out", actual(), {1'b0, 16'd4800, 8'd0, 8'd0});
    check_val("por_ready", cfg_ready, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rel_ready", cfg_ready, 1);
    check_val("rel_busy", busy, 0);

    send(1, 1000, 128, 128);
    check_val("q_enable_len", 64'(q.size()), 64'd97);
    play(1000, 1);
    send(1, 1000, 0, 130);   play(1000, 1);
    send(1, 1000, 64, 128);  play(1000, 1);
    send(1, 2000, 64, 128);  play(1000, 1);
    send(1, 0, 30, 40);      play(1000, 1);
    check_val("clamp_lo", delay_length, 1);
    send(1, 20000, 30, 40);  play(1000, 1);
    check_val("clamp_hi", delay_length, 16384);

    // Second request held valid while the first sequence runs.
    send(1, 5000, 100, 90);
    present(1, 5000, 20, 200);
    play(1000, 0);
    wait_accept();
    build(1, 5000, 20, 200);
    play(1000, 1);

    for (int i = 0; i < 10; i++) begin
      int te, len, sel;
      te  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      sel = $urandom_range(0, 3);
      len = (sel == 0) ? 0 : (sel == 1) ? 20000 : (sel == 2) ? m_len : $urandom_range(1, 20000);
      send(te, len, $urandom_range(0, 255), $urandom_range(0, 255));
      play(1000, 1);
    end

    // Reset landing mid-fade with a request stalled behind it.
    send(1, 3000, 128, 100); play(1000, 1);
    send(0, 3000, 0, 0);     play(5, 0);
    present(1, 3000, 50, 60);
    reset_mid();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_noacc", acc_cnt, acc_seen);
    @(negedge clk);
    reset = 1'b0;
    wait_accept();
    build(1, 3000, 50, 60);
    play(1000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
